// File: rtl/instr_encoder_if.sv
// Descriptor-in / instruction-memory-write-out bundle for instr_encoder, plus session status.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
  );

  modport slave (
    input  start, in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes instruction descriptors into 32-bit words and writes them to consecutive memory words; write lands one
// cycle after the handshake, back-to-back with no bubbles; in_ready drops after the last descriptor or when memory is full.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [ADDR_W:0]   count_q;
  logic [31:0]       wdata_q, word;
  logic              err_q, last_q, we_q;
  logic              busy, done, ready;
  logic              full, wrap_up, accept, op_ok;
  logic [5:0]        opcode, funct;
  logic              is_r, is_shift;

  assign full    = (count_q == CAP);
  assign wrap_up = last_q | full;
  assign accept  = bus.in_valid & ready;
  assign op_ok   = ~bus.in_op[4];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = RUN;
      RUN:        if (wrap_up)   state_d = DONE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    ready = (state_q == RUN) & ~wrap_up;
  end

  always_comb begin
    opcode   = 6'b000000;
    funct    = 6'b000000;
    is_r     = 1'b0;
    is_shift = 1'b0;
    case (bus.in_op)
      5'd0:  begin is_r = 1'b1; funct = 6'b100000; end
      5'd1:  begin is_r = 1'b1; funct = 6'b100010; end
      5'd2:  begin is_r = 1'b1; funct = 6'b100100; end
      5'd3:  begin is_r = 1'b1; funct = 6'b100101; end
      5'd4:  begin is_r = 1'b1; funct = 6'b100110; end
      5'd5:  begin is_r = 1'b1; is_shift = 1'b1; funct = 6'b000000; end
      5'd6:  begin is_r = 1'b1; is_shift = 1'b1; funct = 6'b000010; end
      5'd7:  begin is_r = 1'b1; is_shift = 1'b1; funct = 6'b000011; end
      5'd8:  begin is_r = 1'b1; funct = 6'b101010; end
      5'd9:  begin is_r = 1'b1; funct = 6'b101011; end
      5'd10: opcode = 6'b001000;
      5'd11: opcode = 6'b001101;
      5'd12: opcode = 6'b000100;
      5'd13: opcode = 6'b000010;
      5'd14: opcode = 6'b100011;
      5'd15: opcode = 6'b101011;
      default: ;
    endcase
    // Shifts take their operand from rt, so rs is zeroed; only shifts carry a shamt.
    if (is_r)
      word = {6'b000000, is_shift ? 5'd0 : bus.in_rs, bus.in_rt, bus.in_rd,
              is_shift ? bus.in_shamt : 5'd0, funct};
    else if (bus.in_op == 5'd13)
      word = {opcode, bus.in_target};
    else
      word = {opcode, bus.in_rs, bus.in_rt, bus.in_imm};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= BASE;
      count_q    <= '0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      mem_addr_q <= BASE;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (state_q != RUN) begin
        if (bus.start) begin
          addr_q  <= BASE;
          count_q <= '0;
          err_q   <= 1'b0;
          last_q  <= 1'b0;
        end
      end else if (wrap_up) begin
        if (!last_q) err_q <= 1'b1;
      end else if (accept) begin
        if (bus.in_last) last_q <= 1'b1;
        if (op_ok) begin
          we_q       <= 1'b1;
          mem_addr_q <= addr_q;
          wdata_q    <= word;
          addr_q     <= addr_q + ADDR_W'(1);
          count_q    <= count_q + (ADDR_W + 1)'(1);
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // Reset masks the strobe directly so a write registered just before reset never reaches memory.
  assign bus.mem_we    = we_q & ~rst;
  assign bus.in_ready  = ready & ~rst;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err       = err_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Two encoders (256-word and 4-word memories) share one stimulus stream; each is checked every cycle against a model.
module tb_instr_encoder;
  localparam longint P26 = 64'd1 << 26;
  localparam longint P21 = 64'd1 << 21;
  localparam longint P16 = 64'd1 << 16;
  localparam longint P11 = 64'd1 << 11;
  localparam longint P6  = 64'd1 << 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_last;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  int          checks = 0;
  int          errors = 0;
  int          nwr;

  instr_encoder_if #(.ADDR_W(8)) bus8 ();
  instr_encoder_if #(.ADDR_W(2)) bus2 ();

  assign bus8.start = start;     assign bus2.start = start;
  assign bus8.in_valid = in_valid; assign bus2.in_valid = in_valid;
  assign bus8.in_op = in_op;     assign bus2.in_op = in_op;
  assign bus8.in_rs = in_rs;     assign bus2.in_rs = in_rs;
  assign bus8.in_rt = in_rt;     assign bus2.in_rt = in_rt;
  assign bus8.in_rd = in_rd;     assign bus2.in_rd = in_rd;
  assign bus8.in_shamt = in_shamt; assign bus2.in_shamt = in_shamt;
  assign bus8.in_imm = in_imm;   assign bus2.in_imm = in_imm;
  assign bus8.in_target = in_target; assign bus2.in_target = in_target;
  assign bus8.in_last = in_last; assign bus2.in_last = in_last;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int cap[2]        = '{256, 4};
  int funct_tab[10] = '{32, 34, 36, 37, 38, 0, 2, 3, 42, 43};
  int opc_tab[6]    = '{8, 13, 4, 2, 35, 43};

  // Model of each encoder: session flags, next address, words written, last observed write.
  bit          m_act[2], m_fin[2], m_err[2], m_end[2], m_we[2];
  int          m_nxt[2], m_cnt[2], m_addr[2];
  logic [31:0] m_dat[2];

  // Directed back-to-back sequence with junk in the fields each op must ignore.
  int          v_op[5]  = '{10, 5, 13, 12, 15};
  int          v_rs[5]  = '{0, 7, 9, 1, 0};
  int          v_rt[5]  = '{5, 2, 9, 2, 2};
  int          v_rd[5]  = '{31, 4, 9, 31, 31};
  int          v_sh[5]  = '{31, 3, 9, 31, 31};
  int          v_imm[5] = '{32'hFFFF, 32'h1234, 32'hFFFF, 32'hFFFE, 32'h0004};
  int          v_tgt[5] = '{32'h3FFFFFF, 32'h155, 32'h10, 32'h2AA, 32'h1};
  logic [31:0] v_w[5]   = '{32'h2005FFFF, 32'h000220C0, 32'h08000010, 32'h1022FFFE, 32'hAC020004};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc();
    longint w;
    int     op;
    bit     sh;
    op = int'(in_op);
    if (op < 10) begin
      sh = (op >= 5 && op <= 7);
      w = (sh ? 64'd0 : longint'(in_rs)) * P21 + longint'(in_rt) * P16 + longint'(in_rd) * P11
          + (sh ? longint'(in_shamt) : 64'd0) * P6 + longint'(funct_tab[op]);
    end else if (op == 13) begin
      w = 2 * P26 + longint'(in_target);
    end else begin
      w = longint'(opc_tab[op-10]) * P26 + longint'(in_rs) * P21 + longint'(in_rt) * P16 + longint'(in_imm);
    end
    return w[31:0];
  endfunction

  function automatic bit m_rdy(input int i);
    return m_act[i] && !m_end[i] && m_cnt[i] < cap[i];
  endfunction

  task automatic model_reset(input int i);
    m_act[i] = 0; m_fin[i] = 0; m_err[i] = 0; m_end[i] = 0; m_we[i] = 0;
    m_nxt[i] = 0; m_cnt[i] = 0; m_addr[i] = 0; m_dat[i] = '0;
  endtask

  task automatic model_step(input int i);
    bit hs;
    hs = m_rdy(i) && (in_valid === 1'b1);
    if (rst) begin
      model_reset(i);
    end else begin
      m_we[i] = 0;
      if (!m_act[i]) begin
        if (start) begin
          m_act[i] = 1; m_fin[i] = 0; m_nxt[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_end[i] = 0;
        end
      end else if (m_end[i] || m_cnt[i] == cap[i]) begin
        if (!m_end[i]) m_err[i] = 1;
        m_act[i] = 0;
        m_fin[i] = 1;
      end else if (hs) begin
        m_end[i] = in_last;
        if (in_op < 16) begin
          m_we[i]   = 1;
          m_addr[i] = m_nxt[i];
          m_dat[i]  = enc();
          m_nxt[i]  = (m_nxt[i] + 1) % cap[i];
          m_cnt[i]++;
        end else begin
          m_err[i] = 1;
        end
      end
    end
  endtask

  task automatic check_dut(input int i, input logic rdy, input logic we, input logic [31:0] addr,
                           input logic [31:0] dat, input logic bsy, input logic dn, input logic er,
                           input logic [31:0] cnt);
    chk($sformatf("in_ready[%0d]", i), 32'(rdy), 32'(m_rdy(i) && !rst));
    chk($sformatf("mem_we[%0d]", i), 32'(we), 32'(m_we[i] && !rst));
    chk($sformatf("mem_addr[%0d]", i), addr, 32'(m_addr[i]));
    chk($sformatf("mem_wdata[%0d]", i), dat, m_dat[i]);
    chk($sformatf("busy[%0d]", i), 32'(bsy), 32'(m_act[i]));
    chk($sformatf("done[%0d]", i), 32'(dn), 32'(m_fin[i]));
    chk($sformatf("err[%0d]", i), 32'(er), 32'(m_err[i]));
    chk($sformatf("count[%0d]", i), cnt, 32'(m_cnt[i]));
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0, bus8.in_ready, bus8.mem_we, 32'(bus8.mem_addr), bus8.mem_wdata,
              bus8.busy, bus8.done, bus8.err, 32'(bus8.count));
    check_dut(1, bus2.in_ready, bus2.mem_we, 32'(bus2.mem_addr), bus2.mem_wdata,
              bus2.busy, bus2.done, bus2.err, 32'(bus2.count));
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input bit last);
    start = 0; in_valid = 1; in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    tick();
  endtask

  task automatic idle(input int n);
    start = 0; in_valid = 0; in_last = 0;
    repeat (n) tick();
  endtask

  task automatic go();
    start = 1; in_valid = 0; in_last = 0;
    tick();
    start = 0;
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_last = 0; in_op = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    tick();
    rst = 0;
    chk("rst_count", 32'(bus8.count), 32'd0);
    chk("rst_addr", 32'(bus8.mem_addr), 32'd0);
    chk("rst_busy", 32'(bus8.busy), 32'd0);

    // Single ADD with last.
    go();
    send(0, 1, 2, 3, 9, 32'h1234, 3, 1);
    chk("add_we", 32'(bus8.mem_we), 32'd1);
    chk("add_addr", 32'(bus8.mem_addr), 32'd0);
    chk("add_word", bus8.mem_wdata, 32'h00221820);
    idle(1);
    chk("add_done", 32'(bus8.done), 32'd1);
    chk("add_count", 32'(bus8.count), 32'd1);

    // Back-to-back descriptors, one write per cycle.
    go();
    for (int k = 0; k < 5; k++) begin
      send(v_op[k], v_rs[k], v_rt[k], v_rd[k], v_sh[k], v_imm[k], v_tgt[k], k == 4);
      chk($sformatf("b2b_we%0d", k), 32'(bus8.mem_we), 32'd1);
      chk($sformatf("b2b_addr%0d", k), 32'(bus8.mem_addr), 32'(k));
      chk($sformatf("b2b_word%0d", k), bus8.mem_wdata, v_w[k]);
    end
    idle(2);

    // Invalid op between two valid ones.
    go();
    send(0, 3, 4, 5, 0, 0, 0, 0);
    chk("inv_addr0", 32'(bus8.mem_addr), 32'd0);
    send(20, 1, 1, 1, 1, 1, 1, 0);
    chk("inv_nowrite", 32'(bus8.mem_we), 32'd0);
    send(3, 6, 7, 8, 0, 0, 0, 1);
    chk("inv_addr1", 32'(bus8.mem_addr), 32'd1);
    idle(2);
    chk("inv_err", 32'(bus8.err), 32'd1);
    chk("inv_count", 32'(bus8.count), 32'd2);

    // Capacity on the 4-word encoder: five descriptors without last, fifth held.
    go();
    nwr = 0;
    for (int k = 0; k < 8; k++) begin
      send(10, (k < 5) ? k : 4, 1, 0, 0, (k < 5) ? k : 4, 0, 0);
      if (bus2.mem_we) begin
        chk("cap_addr", 32'(bus2.mem_addr), 32'(nwr));
        nwr++;
      end
    end
    idle(1);
    chk("cap_writes", 32'(nwr), 32'd4);
    chk("cap_ready", 32'(bus2.in_ready), 32'd0);
    chk("cap_err", 32'(bus2.err), 32'd1);
    chk("cap_done", 32'(bus2.done), 32'd1);

    // Reset on the cycle after a handshake.
    rst = 1;
    idle(1);
    rst = 0;
    go();
    send(10, 0, 5, 0, 0, 32'h00AA, 0, 0);
    rst = 1;
    in_valid = 0;
    #1;
    chk("rst_we_gated", 32'(bus8.mem_we), 32'd0);
    tick();
    chk("rst_we_after", 32'(bus8.mem_we), 32'd0);
    chk("rst_idle", 32'(bus8.busy), 32'd0);
    chk("rst_cnt", 32'(bus8.count), 32'd0);
    rst = 0;
    go();
    send(0, 1, 2, 3, 0, 0, 0, 1);
    chk("rst_restart_addr", 32'(bus8.mem_addr), 32'd0);
    chk("rst_restart_we", 32'(bus8.mem_we), 32'd1);
    idle(2);

    // Random traffic; a quiet window without last or reset fills the 256-word memory.
    for (int c = 0; c < 2600; c++) begin
      bit quiet;
      quiet = (c >= 1200 && c < 1800);
      rst = !quiet && ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom); in_shamt = 5'($urandom);
      in_imm = 16'($urandom); in_target = 26'($urandom);
      in_last = !quiet && ($urandom_range(0, 15) == 0);
      tick();
    end
    rst = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 Parameter BASE_ADDR, default 0: first word address written after start.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  pulse; begins a load session from IDLE or DONE.
REQ-006 in_valid  input  1  descriptor valid.
REQ-007 in_ready  output  1  encoder accepts descriptor this cycle.
REQ-008 in_op  input  5  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 ADDI, 11 ORI, 12 BEQ, 13 J, 14 LW, 15 SW; 16-31 invalid.
REQ-009 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift-amount fields.
REQ-010 in_imm  input  16  immediate or branch offset.
REQ-011 in_target  input  26  jump target field.
REQ-012 in_last  input  1  marks final descriptor of the session.
REQ-013 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-014 mem_addr  output  ADDR_W  word address of the write.
REQ-015 mem_wdata  output  32  encoded instruction word.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  high in DONE.
REQ-018 err  output  1  sticky error flag, cleared on start.
REQ-019 count  output  ADDR_W+1  number of words written in the current session.

Function
REQ-020 FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start -> RUN. Same edge: next address = BASE_ADDR, count = 0, err = 0.
- start while in RUN is ignored.
REQ-021 in_ready = (state == RUN) and no terminating condition pending; handshake = in_valid & in_ready.
REQ-022 Each handshake with a valid op registers the encoded word. The cycle after the handshake: mem_we=1, mem_addr = current address, mem_wdata = word. Address then increments by 1 mod 2^ADDR_W and count increments by 1. Latency is exactly 1 cycle.
REQ-023 Back-to-back handshakes on consecutive cycles produce back-to-back writes; no bubbles.
REQ-024 R-type ops (0-9) encode as opcode 000000 | rs | rt | rd | shamt | funct.
- funct values: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SLL 000000, SRL 000010, SRA 000011, SLT 101010, SLTU 101011.
- Shamt field is forced to 0 for non-shift ops.
- Rs field is forced to 0 for SLL/SRL/SRA.
REQ-025 I-type ops encode as opcode | rs | rt | imm, with opcodes ADDI 001000, ORI 001101, BEQ 000100, LW 100011, SW 101011.
REQ-026 J encodes as 000010 | in_target.
REQ-027 Invalid op (16-31) handshake: descriptor is consumed, nothing is written, address and count are unchanged, err is set to 1, session continues.
REQ-028 Handshake with in_last=1 (valid or invalid op): in_ready drops the next cycle. FSM enters DONE on the edge that performs the final write, or on the edge after the handshake if no write is due.
REQ-029 Capacity: when count reaches 2^ADDR_W, in_ready is deasserted. If in_last was not received, err=1 and the FSM enters DONE.
REQ-030 Outside the write cycle: mem_we=0; mem_addr and mem_wdata hold their last values.

Reset
REQ-031 rst=1 at a clock edge forces:
- state IDLE
- mem_we, in_ready, busy, done, err = 0
- count = 0, mem_addr = BASE_ADDR, mem_wdata = 0
REQ-032 Reset mid-session discards any pending write; no mem_we is issued on or after the reset edge.
REQ-033 rst has priority over start and over handshakes in the same cycle.

Verification
REQ-034 Start, then ADD rs=1 rt=2 rd=3, last=1. Required response, one cycle after the handshake: mem_we=1, mem_addr=0, mem_wdata=0x00221820. Then done=1, count=1.
REQ-035 Back-to-back descriptors, no bubbles:
- ADDI rs=0 rt=5 imm=0xFFFF -> 0x2005FFFF @0
- SLL rt=2 rd=4 shamt=3 (in_rs=7) -> 0x000220C0 @1
- J target=0x10 -> 0x08000010 @2
- BEQ rs=1 rt=2 imm=0xFFFE -> 0x1022FFFE @3
- SW rs=0 rt=2 imm=4, last=1 -> 0xAC020004 @4
REQ-036 Invalid op 20 between two valid ops. Required response: no write for the invalid op, err=1, the valid ops land at addresses 0 and 1, count=2.
REQ-037 ADDR_W=2, 5 descriptors with no in_last. Required response: 4 writes at addresses 0-3, then in_ready=0, err=1, done=1, 5th descriptor never accepted.
REQ-038 rst asserted on the cycle after a handshake. Required response: no mem_we, state IDLE, count=0. A new start then writes from BASE_ADDR again.
